// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM states and default operand width.
package divider_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_sub_stage.sv
// Combinational ripple borrow-chain subtractor: difference = minuend - subtrahend - borrow_in.
module div_sub_stage #(
    parameter int unsigned W = 9
) (
    output logic [W-1:0] difference,
    output logic         borrow_out,
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    input  logic         borrow_in
);

    logic [W:0] borrow_c;

    always_comb begin
        borrow_c    = '0;
        difference  = '0;
        borrow_c[0] = borrow_in;
        for (int i = 0; i < int'(W); i++) begin
            difference[i]  = minuend[i] ^ subtrahend[i] ^ borrow_c[i];
            borrow_c[i+1]  = (~minuend[i] & subtrahend[i])
                           | (~(minuend[i] ^ subtrahend[i]) & borrow_c[i]);
        end
        borrow_out = borrow_c[W];
    end

endmodule

// File: rtl/restoring_divider_ctrl.sv
// Multi-cycle unsigned restoring divider, one quotient bit per RUN cycle.
// Define DIVIDER_ZERO_FASTPATH_EN to complete divide-by-zero in one cycle and flag it on DivByZero.
module restoring_divider_ctrl
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef DIVIDER_ZERO_FASTPATH_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted_c, trial_c, step_rem_c;
    logic [WIDTH-1:0] step_dvd_c;
    logic             borrow_c, fast_c, unused_c;

    // Partial remainder never exceeds the divisor between steps, so its MSB is only meaningful after the shift.
    assign unused_c   = rem_q[WIDTH];
    assign shifted_c  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign step_rem_c = borrow_c ? shifted_c : trial_c;
    assign step_dvd_c = {dvd_q[WIDTH-2:0], ~borrow_c};
    assign fast_c     = FAST_EN && Start && (Divisor == '0);

    div_sub_stage #(
        .W (WIDTH + 1)
    ) u_sub (
        .difference (trial_c),
        .borrow_out (borrow_c),
        .minuend    (shifted_c),
        .subtrahend ({1'b0, dvs_q}),
        .borrow_in  (1'b0)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (fast_c) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rmd_d   = Dividend;
                    dbz_d   = 1'b1;
                end else if (Start) begin
                    state_d = RUN;
                    rem_d   = '0;
                    dvd_d   = Dividend;
                    dvs_d   = Divisor;
                    cnt_d   = CNT_W'(WIDTH - 1);
                end
            end
            RUN: begin
                rem_d = step_rem_c;
                dvd_d = step_dvd_c;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = step_dvd_c;
                    rmd_d   = step_rem_c[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quotient  = quo_q;
    assign Remainder = rmd_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_ctrl.sv
// Scoreboard bench for restoring_divider_ctrl: directed cases plus randomized operations vs. an arithmetic model.
// Honours DIVIDER_ZERO_FASTPATH_EN for divide-by-zero timing and flag.
module tb_restoring_divider_ctrl;

    localparam int W = 8;
`ifdef DIVIDER_ZERO_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        int q;
        int r;
        int dbz;
        int done_cyc;
    } exp_t;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [W-1:0] Dividend = '0;
    logic [W-1:0] Divisor = '0;
    logic         Busy, Done, DivByZero;
    logic [W-1:0] Quotient, Remainder;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   run_start = 0;
    bit   run_valid = 1'b0;
    int   held_q = 0, held_r = 0, held_z = 0;
    exp_t sb[$];
    exp_t mon_e;

    restoring_divider_ctrl #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference: plain integer division; divide-by-zero gives all-ones / dividend.
    function automatic exp_t model(input int a, input int b, input int s);
        exp_t e;
        if (b == 0) begin
            e.q        = (1 << W) - 1;
            e.r        = a;
            e.dbz      = FAST ? 1 : 0;
            e.done_cyc = FAST ? s : s + W;
        end else begin
            e.q        = a / b;
            e.r        = a % b;
            e.dbz      = 0;
            e.done_cyc = s + W;
        end
        return e;
    endfunction

    // Monitor: every cycle, compare Busy window, Done pulse and held results.
    always @(posedge Clk) begin
        #1;
        chk("busy", int'(Busy),
            (run_valid && cyc >= run_start && cyc < run_start + W) ? 1 : 0);
        if (sb.size() > 0 && sb[0].done_cyc == cyc) begin
            mon_e = sb.pop_front();
            chk("done_pulse", int'(Done), 1);
            held_q = mon_e.q;
            held_r = mon_e.r;
            held_z = mon_e.dbz;
        end else begin
            chk("done_spurious", int'(Done), 0);
        end
        chk("quotient", int'(Quotient), held_q);
        chk("remainder", int'(Remainder), held_r);
        chk("divbyzero", int'(DivByZero), held_z);
    end

    // Called at a falling edge; Start is sampled on the next rising edge.
    task automatic issue(input int a, input int b, output int dc);
        exp_t e;
        int   s;
        s  = cyc + 1;
        e  = model(a, b, s);
        dc = e.done_cyc;
        sb.push_back(e);
        if (!(FAST && b == 0)) begin
            run_start = s;
            run_valid = 1'b1;
        end
        Start    = 1'b1;
        Dividend = W'(a);
        Divisor  = W'(b);
        @(negedge Clk);
        Start    = 1'b0;
        Dividend = W'($urandom);
        Divisor  = W'($urandom);
    endtask

    // Advance to a target cycle; optional noise on Start/operands while the DUT is iterating.
    task automatic run_to(input int target, input bit noise);
        int guard;
        guard = 0;
        while (cyc < target && guard < 1000) begin
            if (noise) begin
                Start    = 1'($urandom);
                Dividend = W'($urandom);
                Divisor  = W'($urandom);
            end
            @(negedge Clk);
            guard++;
        end
        Start = 1'b0;
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        Start     = 1'b0;
        sb.delete();
        run_valid = 1'b0;
        held_q    = 0;
        held_r    = 0;
        held_z    = 0;
        #1;
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_quotient", int'(Quotient), 0);
        chk("rst_remainder", int'(Remainder), 0);
        chk("rst_divbyzero", int'(DivByZero), 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        int dc, a, b, gap;
        repeat (2) @(negedge Clk);
        chk("init_busy", int'(Busy), 0);
        chk("init_quotient", int'(Quotient), 0);
        chk("init_remainder", int'(Remainder), 0);
        Reset = 1'b0;
        @(negedge Clk);

        issue(200, 7, dc);  run_to(dc, 1'b1); @(negedge Clk);
        issue(255, 1, dc);  run_to(dc, 1'b1); @(negedge Clk);
        issue(5, 9, dc);    run_to(dc, 1'b1); @(negedge Clk);
        issue(0, 5, dc);    run_to(dc, 1'b0); @(negedge Clk);
        issue(255, 255, dc); run_to(dc, 1'b0); @(negedge Clk);

        issue(100, 10, dc); run_to(dc, 1'b0);
        issue(17, 3, dc);   run_to(dc, 1'b0); @(negedge Clk);

        issue(200, 7, dc);
        run_to(dc - W + 3, 1'b0);
        do_reset();
        @(negedge Clk);
        issue(9, 2, dc);    run_to(dc, 1'b0); @(negedge Clk);

        issue(77, 0, dc);   run_to(dc, 1'b0); @(negedge Clk);
        issue(255, 0, dc);  run_to(dc, 1'b0);
        issue(13, 0, dc);   run_to(dc, 1'b0); @(negedge Clk);

        for (int n = 0; n < 60; n++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
            issue(a, b, dc);
            run_to(dc, !(FAST && b == 0));
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge Clk);
        end

        repeat (3) @(negedge Clk);
        chk("drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
